bit_reorder_prog: RTL and testbench

Runtime-programmable, registered bit permutation unit. It generalises the fixed-parameter bit reorder primitive to any DATA_WIDTH, with the permutation map held in a double-buffered register table instead of elaboration-time parameters. It sits in streaming datapaths between packetisers and ADC or FPGA interfaces, with a valid/ready handshake on both sides. Map updates are staged in a shadow table and take effect atomically on commit.

---
 rtl/bit_reorder_prog.sv | 117 +++++++++++
 tb/tb_bit_reorder_prog.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_reorder_prog.sv
`default_nettype none
// ============================================================================
// Module  : bit_reorder_prog
// Brief   : Registered bit permutation with a runtime-programmable,
//           double-buffered map and valid/ready handshake on both sides.
// Rev     : 1.0  initial release
// ============================================================================
module bit_reorder_prog #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   cfg_wr_en,
    input  logic [INDEX_WIDTH-1:0] cfg_addr,
    input  logic [INDEX_WIDTH-1:0] cfg_data,
    input  logic                   cfg_commit,
    output logic                   cfg_busy
);

    logic [INDEX_WIDTH-1:0] r_active_q [DATA_WIDTH];
    logic [INDEX_WIDTH-1:0] r_shadow_q [DATA_WIDTH];
    logic [INDEX_WIDTH-1:0] w_active_d [DATA_WIDTH];
    logic [INDEX_WIDTH-1:0] w_shadow_d [DATA_WIDTH];
    logic [DATA_WIDTH-1:0]  r_out_data_q;
    logic [DATA_WIDTH-1:0]  w_out_data_d;
    logic                   r_out_valid_q;
    logic                   w_out_valid_d;
    logic                   r_busy_q;
    logic                   w_busy_d;
    logic [DATA_WIDTH-1:0]  w_reordered;
    logic                   w_in_xfer;
    logic                   w_wr_accept;

    // Each output bit is a mux over all input bits; an entry matching no
    // input index (>= DATA_WIDTH) selects nothing and yields 0.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_out_bit
        logic w_bit;
        always_comb begin
            w_bit = 1'b0;
            for (int j = 0; j < DATA_WIDTH; j++) begin
                if (r_active_q[gi] == INDEX_WIDTH'(j)) begin
                    w_bit = in_data[j];
                end
            end
        end
        assign w_reordered[gi] = w_bit;
    end

    assign in_ready  = !r_out_valid_q || out_ready;
    assign w_in_xfer = in_valid && in_ready;

    always_comb begin
        w_out_valid_d = r_out_valid_q;
        w_out_data_d  = r_out_data_q;
        if (w_in_xfer) begin
            w_out_valid_d = 1'b1;
            w_out_data_d  = w_reordered;
        end else if (out_ready) begin
            w_out_valid_d = 1'b0;
        end
    end

    // Commit copies the shadow as it stood before this cycle's write, so a
    // write coinciding with a commit waits for the following commit.
    always_comb begin
        w_active_d  = r_active_q;
        w_shadow_d  = r_shadow_q;
        w_wr_accept = 1'b0;
        if (cfg_commit) begin
            w_active_d = r_shadow_q;
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (cfg_wr_en && (cfg_addr == INDEX_WIDTH'(i))) begin
                w_shadow_d[i] = cfg_data;
                w_wr_accept   = 1'b1;
            end
        end
        w_busy_d = r_busy_q;
        if (cfg_commit) begin
            w_busy_d = 1'b0;
        end
        if (w_wr_accept) begin
            w_busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid_q <= 1'b0;
            r_out_data_q  <= '0;
            r_busy_q      <= 1'b0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                r_active_q[i] <= INDEX_WIDTH'(i);
                r_shadow_q[i] <= INDEX_WIDTH'(i);
            end
        end else begin
            r_out_valid_q <= w_out_valid_d;
            r_out_data_q  <= w_out_data_d;
            r_busy_q      <= w_busy_d;
            r_active_q    <= w_active_d;
            r_shadow_q    <= w_shadow_d;
        end
    end

    assign out_data  = r_out_data_q;
    assign out_valid = r_out_valid_q;
    assign cfg_busy  = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_reorder_prog.sv
`default_nettype none
// ============================================================================
// Module  : tb_bit_reorder_prog
// Brief   : Directed bench for bit_reorder_prog with a reference map model
//           feeding an output scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_bit_reorder_prog;

    localparam int DW = 32;
    localparam int IW = 6;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          cfg_wr_en;
    logic [IW-1:0] cfg_addr;
    logic [IW-1:0] cfg_data;
    logic          cfg_commit;
    logic          cfg_busy;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] sb[$];
    int            m_active[DW];
    int            m_shadow[DW];
    logic          m_busy;

    bit_reorder_prog #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_map(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) begin
            r[i] = (m_active[i] < DW) ? d[m_active[i]] : 1'b0;
        end
        return r;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_busy = 1'b0;
        for (int i = 0; i < DW; i++) begin
            m_active[i] = i;
            m_shadow[i] = i;
        end
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so the negedge
    // sees exactly what the DUT will sample at the coming edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            chk("valid_vs_sb", {31'd0, out_valid}, {31'd0, sb.size() != 0});
            chk("busy", {31'd0, cfg_busy}, {31'd0, m_busy});
            if (out_valid && out_ready && sb.size() != 0) begin
                chk("sb_data", out_data, sb.pop_front());
            end
            if (in_valid && in_ready) begin
                sb.push_back(model_map(in_data));
            end
            if (cfg_commit) begin
                m_active = m_shadow;
                m_busy   = 1'b0;
            end
            if (cfg_wr_en && cfg_addr < DW) begin
                m_shadow[cfg_addr] = int'(cfg_data);
                m_busy = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input logic [DW-1:0] w);
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_wr_en = 1'b1;
        cfg_addr  = IW'(a);
        cfg_data  = IW'(d);
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_wr_en = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        model_reset();

        // Reset, then identity pass-through.
        tick();
        chk("rst_valid0", {31'd0, out_valid}, 32'd0);
        tick();
        chk("rst_valid1", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_busy", {31'd0, cfg_busy}, 32'd0);
        rst = 1'b1;
        send(32'hF0F0_F0F0);
        chk("id_valid", {31'd0, out_valid}, 32'd1);
        chk("id_data", out_data, 32'hF0F0_F0F0);
        idle(1);
        chk("id_drain", {31'd0, out_valid}, 32'd0);

        // out[7:0] = {in4,in3,in2,in1,in7,in6,in5,in0} -> 8'h8E for 8'hF0.
        cfg_write(1, 5); cfg_write(2, 6); cfg_write(3, 7); cfg_write(4, 1);
        cfg_write(5, 2); cfg_write(6, 3); cfg_write(7, 4);
        chk("busy_set", {31'd0, cfg_busy}, 32'd1);
        commit();
        chk("busy_clr", {31'd0, cfg_busy}, 32'd0);
        send(32'hF0F0_F0F0);
        chk("byte_map", out_data, 32'hF0F0_F08E);
        idle(1);

        // Bit reversal; word in the commit cycle still uses the old map.
        for (int i = 0; i < DW; i++) cfg_write(i, DW - 1 - i);
        cfg_commit = 1'b1; in_data = 32'h1; in_valid = 1'b1;
        tick();
        chk("rev_old", out_data, 32'h1);
        cfg_commit = 1'b0;
        tick();
        chk("rev_new", out_data, 32'h8000_0000);
        in_valid = 1'b0;
        idle(1);

        // Back to identity, then backpressure.
        for (int i = 0; i < DW; i++) cfg_write(i, i);
        commit();
        send(32'd1);
        out_ready = 1'b0; in_data = 32'd2; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_data", out_data, 32'd1);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_out2", out_data, 32'd2);
        in_data = 32'd3;
        tick();
        chk("bp_out3", out_data, 32'd3);
        in_valid = 1'b0;
        idle(1);
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Map edge cases: ignored address, top index, write during commit.
        cfg_write(40, 0);
        chk("addr40_ignored", {31'd0, cfg_busy}, 32'd0);
        cfg_write(0, 31);
        commit();
        send(32'h8000_0000);
        chk("bit0_from31", out_data, 32'h8000_0001);
        cfg_wr_en = 1'b1; cfg_addr = IW'(2); cfg_data = IW'(31); cfg_commit = 1'b1;
        tick();
        cfg_wr_en = 1'b0; cfg_commit = 1'b0;
        chk("wr_commit_busy", {31'd0, cfg_busy}, 32'd1);
        send(32'h8000_0000);
        chk("bit2_pending", out_data, 32'h8000_0001);
        commit();
        send(32'h8000_0000);
        chk("bit2_applied", out_data, 32'h8000_0005);
        cfg_write(31, 40);
        commit();
        send(32'hFFFF_FFFF);
        chk("zero_fill", out_data, 32'h7FFF_FFFF);

        // Reset with a held word, a pending write and a non-identity map.
        cfg_write(5, 9);
        out_ready = 1'b0;
        send(32'h1234_5678);
        chk("mid_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b0;
        tick();
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_busy", {31'd0, cfg_busy}, 32'd0);
        rst = 1'b1; out_ready = 1'b1;
        send(32'h0000_0002);
        chk("post_rst_2", out_data, 32'h0000_0002);
        send(32'h8000_0000);
        chk("post_rst_id", out_data, 32'h8000_0000);
        idle(2);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
